cache_miss_ctrl: RTL and testbench

Controller between the CPU load/store port and the 2-way data cache. Loads that hit are served combinationally with no stall. Load misses stall the CPU, fetch the word from main memory over a req/ack bus, fill the cache and return the data. Stores are write-through (memory, then cache). The block also keeps saturating hit/miss performance counters.

---
 rtl/cache_miss_ctrl_pkg.sv | 19 +
 rtl/cache_miss_ctrl_if.sv | 43 ++++
 rtl/cache_miss_ctrl_sat_counter.sv | 18 +
 rtl/cache_miss_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_miss_ctrl_pkg.sv
// Shared types and address-field constants for the
// data-cache miss controller.
package cache_pkg;

  localparam int OFFSET_W = 2;
  localparam int SET_W    = 7;
  localparam int TAG_W    = 23;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    FILL,
    WR_MEM,
    WR_CACHE,
    DONE
  } state_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU load/store port and main-memory req/ack bus.
// master drives the request, slave answers it.
interface cpu_port_if;
  import cache_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              stall;

  modport master (
    output req, we, addr, wdata,
    input  rdata, stall
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, stall
  );
endinterface

interface mem_bus_if;
  import cache_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Load-miss / write-through controller between the CPU
// port, the 2-way data cache and main memory.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  cpu_port_if.slave         cpu,
  mem_bus_if.master         mem,
  input  logic              cache_hit,
  input  logic [WORD_W-1:0] cache_rdata,
  output logic [WORD_W-1:0] cache_addr,
  output logic              cache_we,
  output logic [WORD_W-1:0] cache_wdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_t            state;
  logic [WORD_W-1:0] fill_buf;
  logic [WORD_W-1:0] st_data;
  logic              ld_op;

  logic idle;
  logic ld_hit;
  logic ld_miss;
  logic st_go;

  assign idle    = (state == IDLE);
  assign ld_hit  = idle & cpu.req & ~cpu.we & cache_hit;
  assign ld_miss = idle & cpu.req & ~cpu.we & ~cache_hit;
  assign st_go   = idle & cpu.req & cpu.we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fill_buf <= '0;
      st_data  <= '0;
      ld_op    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_miss) begin
            state <= RD_MEM;
            ld_op <= 1'b1;
          end else if (st_go) begin
            state   <= WR_MEM;
            st_data <= cpu.wdata;
            ld_op   <= 1'b0;
          end
        end
        RD_MEM: begin
          if (mem.ack) begin
            fill_buf <= mem.rdata;
            state    <= FILL;
          end
        end
        FILL:     state <= DONE;
        WR_MEM:   if (mem.ack) state <= WR_CACHE;
        WR_CACHE: state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from the state register so
  // an asynchronous reset drops them without a clock.
  always_comb begin
    cpu.stall   = 1'b0;
    cpu.rdata   = '0;
    mem.req     = 1'b0;
    mem.we      = 1'b0;
    mem.addr    = '0;
    mem.wdata   = '0;
    cache_addr  = cpu.addr;
    cache_we    = 1'b0;
    cache_wdata = '0;
    unique case (state)
      IDLE: begin
        cpu.stall = cpu.req & (cpu.we | ~cache_hit);
        if (ld_hit)
          cpu.rdata = cache_rdata;
      end
      RD_MEM: begin
        cpu.stall = 1'b1;
        mem.req   = 1'b1;
        mem.addr  = cpu.addr;
      end
      FILL: begin
        cpu.stall   = 1'b1;
        cache_we    = 1'b1;
        cache_wdata = fill_buf;
      end
      WR_MEM: begin
        cpu.stall = 1'b1;
        mem.req   = 1'b1;
        mem.we    = 1'b1;
        mem.addr  = cpu.addr;
        mem.wdata = st_data;
      end
      WR_CACHE: begin
        cpu.stall   = 1'b1;
        cache_we    = 1'b1;
        cache_wdata = st_data;
      end
      DONE: begin
        if (ld_op)
          cpu.rdata = fill_buf;
      end
      default: ;
    endcase
    if (!rst) begin
      cpu.stall = 1'b0;
      cpu.rdata = '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ld_hit),
    .cnt (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ld_miss),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: vector table, scoreboard of
// expected load data, reset and saturation sequences.
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cache_hit;
  logic [WORD_W-1:0] cache_rdata;
  logic [WORD_W-1:0] cache_addr;
  logic              cache_we;
  logic [WORD_W-1:0] cache_wdata;
  logic [CW-1:0]     hit_cnt;
  logic [CW-1:0]     miss_cnt;

  cpu_port_if cpu ();
  mem_bus_if  mem ();

  cache_miss_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu),
    .mem         (mem),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .cache_addr  (cache_addr),
    .cache_we    (cache_we),
    .cache_wdata (cache_wdata),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crd;
    logic [31:0] mrd;
    int          waits;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int m_hit  = 0;
  int m_miss = 0;
  logic [31:0] sb[$];
  vec_t tbl[6];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(int m);
    return 32'((m > MAX) ? MAX : m);
  endfunction

  task automatic access(vec_t v);
    logic [31:0] e;
    int   stalls;
    int   reqc;
    int   cwe;
    bit   done;
    bit   quick;
    quick = !v.we && v.hit;
    stalls = 0;
    reqc = 0;
    cwe = 0;
    done = 0;
    cpu.req     = 1'b1;
    cpu.we      = v.we;
    cpu.addr    = v.addr;
    cpu.wdata   = v.wdata;
    cache_hit   = v.hit;
    cache_rdata = v.crd;
    sb.push_back(v.we ? 32'h0 : (v.hit ? v.crd : v.mrd));
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0)
        chk("cache_addr", cache_addr, v.addr);
      if (mem.req) begin
        reqc++;
        chk("mem_addr", mem.addr, v.addr);
        chk("mem_we", 32'(mem.we), 32'(v.we));
        if (v.we)
          chk("mem_wdata", mem.wdata, v.wdata);
        mem.ack   = (reqc == v.waits + 1);
        mem.rdata = v.mrd;
      end else begin
        mem.ack = 1'b0;
      end
      if (cache_we) begin
        cwe++;
        chk("cache_wdata", cache_wdata, v.we ? v.wdata : v.mrd);
      end
      if (cpu.stall) begin
        stalls++;
      end else begin
        e = sb.pop_front();
        chk("cpu_rdata", cpu.rdata, e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    mem.ack = 1'b0;
    cpu.req = 1'b0;
    cpu.we  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: got no completion want one");
      void'(sb.pop_front());
    end
    chk("stall_cycles", 32'(stalls), quick ? 0 : 32'(3 + v.waits));
    chk("mem_req_cycles", 32'(reqc), quick ? 0 : 32'(1 + v.waits));
    chk("cache_we_cycles", 32'(cwe), quick ? 0 : 1);
    if (quick)
      m_hit++;
    else if (!v.we)
      m_miss++;
  endtask

  task automatic chk_cnt(string tag);
    chk({tag, "_hit_cnt"}, 32'(hit_cnt), sat(m_hit));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), sat(m_miss));
  endtask

  initial begin
    vec_t hv;
    tbl[0] = '{1'b0, 32'h0000_0104, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0, 0};
    tbl[1] = '{1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 4};
    tbl[2] = '{1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 0};
    tbl[3] = '{1'b0, 32'h0000_0108, 32'h0, 1'b1, 32'hCAFE_F00D, 32'h0, 0};
    tbl[4] = '{1'b0, 32'h0000_0204, 32'h0, 1'b0, 32'h0, 32'h0BAD_F00D, 0};
    tbl[5] = '{1'b1, 32'h0000_0304, 32'h5A5A_5A5A, 1'b0, 32'h0, 32'h0, 2};

    // Reset held with a live request and a stray ack.
    cpu.req     = 1'b1;
    cpu.we      = 1'b0;
    cpu.addr    = 32'h0;
    cpu.wdata   = 32'h0;
    cache_hit   = 1'b0;
    cache_rdata = 32'h0;
    mem.ack     = 1'b1;
    mem.rdata   = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(cpu.stall), 0);
    chk("rst_rdata", cpu.rdata, 0);
    chk("rst_mem_req", 32'(mem.req), 0);
    chk("rst_mem_we", 32'(mem.we), 0);
    chk("rst_mem_addr", mem.addr, 0);
    chk("rst_mem_wdata", mem.wdata, 0);
    chk("rst_cache_we", 32'(cache_we), 0);
    chk("rst_cache_wdata", cache_wdata, 0);
    chk_cnt("rst");
    cpu.req = 1'b0;
    mem.ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      access(tbl[i]);
    chk_cnt("table");

    // Reset lands while the load miss waits in RD_MEM.
    cpu.req   = 1'b1;
    cpu.we    = 1'b0;
    cpu.addr  = 32'h0000_0400;
    cache_hit = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_mem_req_on", 32'(mem.req), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_mem_req_off", 32'(mem.req), 0);
    chk("mid_stall", 32'(cpu.stall), 0);
    mem.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_cache_we", 32'(cache_we), 0);
    end
    cpu.req = 1'b0;
    mem.ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    m_hit  = 0;
    m_miss = 0;
    @(posedge clk);
    #1;
    chk_cnt("after_rst");
    access(tbl[0]);
    chk_cnt("post_rst_hit");

    // Hit counter must stick at its maximum.
    for (int i = 0; i < 17; i++) begin
      hv = tbl[3];
      hv.addr = 32'h0000_0100 + 32'(i * 4);
      hv.crd  = $urandom;
      access(hv);
    end
    chk_cnt("sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
